stb_dcache_drain: RTL and testbench
===================================

# stb_dcache_drain

Drain engine between the store buffer FIFO and the data cache write port. It pulls the head entry from the store buffer and registers it. It then issues a held write request to the DCache, and on acknowledge pops the entry with a one-cycle pulse. It also handles fence-style flush requests and flags loads that hit the word currently in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write data width
- BYTE_SEL_WIDTH, 4, byte-select width; also sets the word granularity, OFS = $clog2(BYTE_SEL_WIDTH)
- TIMEOUT_CYCLES, 64, ack watchdog limit; used only with STB_DRAIN_TIMEOUT_EN

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stb_valid  in  1  store buffer non-empty (driven from !stb_empty)
- stb_addr  in  ADDR_WIDTH  head entry address, valid while stb_rd_sel=1
- stb_wdata  in  DATA_WIDTH  head entry data
- stb_sel_byte  in  BYTE_SEL_WIDTH  head entry byte select
- stb_rd_sel  out  1  present head entry (store buffer rd_sel)
- stb_pop  out  1  one-cycle pulse; advance store buffer read pointer (r_en)
- stb2dcache_req  out  1  DCache write request
- stb2dcache_w_en  out  1  write enable; equal to stb2dcache_req
- stb2dcache_addr  out  ADDR_WIDTH  registered address
- stb2dcache_wdata  out  DATA_WIDTH  registered data
- stb2dcache_sel_byte  out  BYTE_SEL_WIDTH  registered byte select
- dcache2stb_ack  in  1  DCache write complete; also routed to the store buffer
- flush_req  in  1  fence: drain all entries
- flush_done  out  1  one-cycle pulse, flush complete
- ld_addr  in  ADDR_WIDTH  address of a concurrent LSU load
- ld_hazard  out  1  load word matches the in-flight store
- drain_busy  out  1  state != IDLE
- timeout_err  out  1  sticky ack-timeout error

## Operation
- FSM states:
  - IDLE: start state.
  - WAIT_ACK: request outstanding.
  - GAP: one-cycle bubble so the registered stb_empty can settle after a pop.
- IDLE:
  - stb_rd_sel = stb_valid (combinational).
  - If stb_valid: capture stb_addr/wdata/sel_byte into the output registers at the clock edge and go to WAIT_ACK.
- WAIT_ACK:
  - stb2dcache_req = stb2dcache_w_en = 1.
  - Output registers hold stable.
  - stb_pop = dcache2stb_ack (combinational).
  - On ack, go to GAP; otherwise stay in WAIT_ACK.
- GAP: no req and no rd_sel; go to IDLE.
- dcache2stb_ack outside WAIT_ACK is ignored: no pop, no state change.
- Output data registers keep their last value after the ack. Consumers qualify them with req.
- Flush:
  - flush_req=1 in any cycle sets flush_pend.
  - When state=IDLE, stb_valid=0 and flush_pend=1, pulse flush_done for one cycle and clear flush_pend.
  - Stores arriving during a flush are drained before flush_done.
  - flush_req while already idle and empty gives flush_done the next cycle.
  - flush_req asserted in the same cycle as done re-sets flush_pend (set wins).
- Hazard: ld_hazard = (state==WAIT_ACK) && (ld_addr[ADDR_WIDTH-1:OFS] == stb2dcache_addr[ADDR_WIDTH-1:OFS]).
  - Combinational; the low OFS bits are ignored.
- Reset:
  - All outputs and registers go to 0: req, w_en, addr, wdata, sel_byte, stb_pop, stb_rd_sel, flush_done, ld_hazard, drain_busy, timeout_err.
  - flush_pend is cleared and the state returns to IDLE.
  - Reset mid-WAIT_ACK abandons the request without a pop. The store buffer is reset by the same reset.

## Timing
- stb_valid=1 in IDLE at cycle N: stb_rd_sel=1 in N; req=1 from N+1.
- Ack sampled in cycle M (M ≥ N+1): stb_pop=1 in M; req=0 and state GAP in M+1; IDLE in M+2.
- Earliest next stb_rd_sel is M+2. Minimum issue interval is 3 cycles (ack in first WAIT_ACK cycle).
- req is never deasserted before ack. Exactly one stb_pop per accepted request.

## Configuration
- STB_DRAIN_TIMEOUT_EN defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack, saturating.
  - When it reaches TIMEOUT_CYCLES, timeout_err goes to 1 and stays set until rst.
  - The request is not aborted.
- STB_DRAIN_TIMEOUT_EN undefined: no counter; timeout_err is constant 0.

## Test plan
- Reset with stb_valid=1 held → all outputs 0; after release, stb_rd_sel=1 and req=1 one cycle later with addr=0x1000_0040, wdata=0xDEAD_BEEF, sel_byte=4'b1111.
- Three queued stores, ack delayed 2 cycles each → three req windows, exactly three stb_pop pulses, writes issued in FIFO order, 2-cycle GAP/IDLE bubble between requests.
- Spurious ack while idle → no stb_pop, state stays IDLE, drain_busy=0.
- flush_req with 2 entries queued → flush_done pulses once, one cycle after the second pop's GAP→IDLE with stb_valid=0; flush_req while empty → flush_done next cycle.
- In-flight addr 0x2000_0008, ld_addr=0x2000_000B → ld_hazard=1; ld_addr=0x2000_000C → 0; after the ack cycle → 0.
- STB_DRAIN_TIMEOUT_EN with TIMEOUT_CYCLES=8 and ack withheld → timeout_err=1 after 8 WAIT_ACK cycles, req still 1; it stays 1 after a late ack until rst.

Source files
------------

// File: rtl/stb_dcache_drain_if.sv
// stb_dcache_drain_if: store buffer, DCache write port, flush and load-hazard signals of the drain engine
interface stb_dcache_drain_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4
);
  logic                      stb_valid;
  logic [ADDR_WIDTH-1:0]     stb_addr;
  logic [DATA_WIDTH-1:0]     stb_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb_sel_byte;
  logic                      stb_rd_sel;
  logic                      stb_pop;
  logic                      stb2dcache_req;
  logic                      stb2dcache_w_en;
  logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
  logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
  logic                      dcache2stb_ack;
  logic                      flush_req;
  logic                      flush_done;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic                      ld_hazard;
  logic                      drain_busy;
  logic                      timeout_err;
  modport master (
    input  stb_valid, stb_addr, stb_wdata, stb_sel_byte, dcache2stb_ack, flush_req, ld_addr,
    output stb_rd_sel, stb_pop, stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
           stb2dcache_wdata, stb2dcache_sel_byte, flush_done, ld_hazard, drain_busy, timeout_err
  );
  modport slave (
    output stb_valid, stb_addr, stb_wdata, stb_sel_byte, dcache2stb_ack, flush_req, ld_addr,
    input  stb_rd_sel, stb_pop, stb2dcache_req, stb2dcache_w_en, stb2dcache_addr,
           stb2dcache_wdata, stb2dcache_sel_byte, flush_done, ld_hazard, drain_busy, timeout_err
  );
endinterface

// File: rtl/stb_dcache_drain.sv
// stb_dcache_drain: store buffer to DCache drain engine with flush and load hazard; STB_DRAIN_TIMEOUT_EN adds an ack watchdog
module stb_dcache_drain #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_SEL_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  stb_dcache_drain_if.master bus
);
  localparam int OFS = $clog2(BYTE_SEL_WIDTH);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;
  state_t                    r_state, w_state_nxt;
  logic                      r_flush_pend;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [BYTE_SEL_WIDTH-1:0] r_sel_byte;
  logic                      w_idle, w_wait, w_rd_sel, w_pop, w_flush_done;
  assign w_idle = r_state == IDLE;
  assign w_wait = r_state == WAIT_ACK;
  // rd_sel is gated by rst so the head is not presented while the FIFO is held in reset
  always_comb begin
    w_rd_sel     = w_idle & bus.stb_valid & ~rst;
    w_pop        = w_wait & bus.dcache2stb_ack;
    w_flush_done = w_idle & ~bus.stb_valid & r_flush_pend;
    w_state_nxt  = w_rd_sel ? WAIT_ACK : w_pop ? GAP : (r_state == GAP) ? IDLE : r_state;
  end
  // state, pending flush (a new request wins over the clear) and the captured head entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel_byte   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= bus.flush_req | (r_flush_pend & ~w_flush_done);
      if (w_rd_sel) begin
        r_addr     <= bus.stb_addr;
        r_wdata    <= bus.stb_wdata;
        r_sel_byte <= bus.stb_sel_byte;
      end
    end
  assign bus.stb_rd_sel          = w_rd_sel;
  assign bus.stb_pop             = w_pop;
  assign bus.stb2dcache_req      = w_wait;
  assign bus.stb2dcache_w_en     = w_wait;
  assign bus.stb2dcache_addr     = r_addr;
  assign bus.stb2dcache_wdata    = r_wdata;
  assign bus.stb2dcache_sel_byte = r_sel_byte;
  assign bus.flush_done          = w_flush_done;
  assign bus.drain_busy          = ~w_idle;
  assign bus.ld_hazard           = w_wait & (bus.ld_addr[ADDR_WIDTH-1:OFS] == r_addr[ADDR_WIDTH-1:OFS]);
`ifdef STB_DRAIN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt, w_cnt_nxt;
  logic          r_timeout_err;
  // wait counter restarts on each new request and saturates at the limit
  always_comb begin
    w_cnt_nxt = w_rd_sel ? '0 :
                (w_wait & ~bus.dcache2stb_ack & (r_wait_cnt != CW'(TIMEOUT_CYCLES))) ? r_wait_cnt + CW'(1) :
                r_wait_cnt;
  end
  // sticky error; the outstanding request keeps waiting for its ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt    <= w_cnt_nxt;
      r_timeout_err <= r_timeout_err | (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
    end
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_stb_dcache_drain.sv
// tb_stb_dcache_drain: cycle-by-cycle vector table plus reset and watchdog sequences
module tb_stb_dcache_drain;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  stb_dcache_drain_if bus ();
  stb_dcache_drain #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ack;
    logic        fl;
    logic [31:0] la;
    logic [75:0] exp;
  } vec_t;
  vec_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ea = '0;
  logic [31:0] ed = '0;
  logic [3:0]  es = '0;
  function automatic logic [75:0] obs();
    return {bus.stb_rd_sel, bus.stb_pop, bus.stb2dcache_req, bus.stb2dcache_w_en, bus.stb2dcache_addr,
            bus.stb2dcache_wdata, bus.stb2dcache_sel_byte, bus.flush_done, bus.ld_hazard,
            bus.drain_busy, bus.timeout_err};
  endfunction
  function automatic logic [75:0] mk(logic rd, logic pop, logic req, logic fd, logic hz, logic busy, logic te);
    return {rd, pop, req, req, ea, ed, es, fd, hz, busy, te};
  endfunction
  task automatic cap(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ea = a; ed = d; es = s;
  endtask
  task automatic add(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic ack, input logic fl, input logic [31:0] la,
                     input logic rd, input logic pop, input logic req, input logic fd, input logic hz, input logic busy);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.s = s; t.ack = ack; t.fl = fl; t.la = la;
    t.exp = mk(rd, pop, req, fd, hz, busy, 1'b0);
    q.push_back(t);
  endtask
  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ack, input logic fl, input logic [31:0] la);
    bus.stb_valid = v; bus.stb_addr = a; bus.stb_wdata = d; bus.stb_sel_byte = s;
    bus.dcache2stb_ack = ack; bus.flush_req = fl; bus.ld_addr = la;
  endtask
  task automatic check(input string nm, input logic [75:0] exp);
    n_chk++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, obs(), exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    set_in(1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold_valid", '0);
    // store through reset release, then spurious ack while idle
    add(1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h1000_0040, 32'hDEAD_BEEF, 4'hF);
    add(1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // three queued stores, ack after two wait cycles each
    add(1, 32'h3000_0000, 32'h1111_1111, 4'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h3000_0000, 32'h1111_1111, 4'h1);
    for (int k = 0; k < 2; k++) add(1, 32'h3000_0000, 32'h1111_1111, 4'h1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 32'h3000_0000, 32'h1111_1111, 4'h1, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 32'h3000_0004, 32'h2222_2222, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 32'h3000_0004, 32'h2222_2222, 4'h3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h3000_0004, 32'h2222_2222, 4'h3);
    for (int k = 0; k < 2; k++) add(1, 32'h3000_0004, 32'h2222_2222, 4'h3, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 32'h3000_0004, 32'h2222_2222, 4'h3, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 32'h3000_0008, 32'h3333_3333, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 32'h3000_0008, 32'h3333_3333, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h3000_0008, 32'h3333_3333, 4'hF);
    for (int k = 0; k < 2; k++) add(1, 32'h3000_0008, 32'h3333_3333, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 32'h3000_0008, 32'h3333_3333, 4'hF, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush with two entries queued
    add(1, 32'h4000_0000, 32'hAAAA_AAAA, 4'hF, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h4000_0000, 32'hAAAA_AAAA, 4'hF);
    add(1, 32'h4000_0000, 32'hAAAA_AAAA, 4'hF, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 32'h4000_0004, 32'hBBBB_BBBB, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 32'h4000_0004, 32'hBBBB_BBBB, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cap(32'h4000_0004, 32'hBBBB_BBBB, 4'hF);
    add(1, 32'h4000_0004, 32'hBBBB_BBBB, 4'hF, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush while empty, then flush re-asserted in the done cycle
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load hazard against the in-flight word
    add(1, 32'h2000_0008, 32'h5555_5555, 4'h4, 0, 0, 32'h2000_000B, 1, 0, 0, 0, 0, 0);
    cap(32'h2000_0008, 32'h5555_5555, 4'h4);
    add(1, 32'h2000_0008, 32'h5555_5555, 4'h4, 0, 0, 32'h2000_000B, 0, 0, 1, 0, 1, 1);
    add(1, 32'h2000_0008, 32'h5555_5555, 4'h4, 0, 0, 32'h2000_000C, 0, 0, 1, 0, 0, 1);
    add(1, 32'h2000_0008, 32'h5555_5555, 4'h4, 1, 0, 32'h2000_0008, 0, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h2000_000B, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h2000_000B, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      set_in(q[i].v, q[i].a, q[i].d, q[i].s, q[i].ack, q[i].fl, q[i].la);
      @(negedge clk);
      check($sformatf("vec%0d", i), q[i].exp);
      step();
    end
    // reset in the middle of an outstanding request
    set_in(1, 32'h6000_0000, 32'h6666_6666, 4'hF, 0, 0, 0);
    @(negedge clk);
    check("mid_rst_rdsel", mk(1, 0, 0, 0, 0, 0, 0));
    step();
    cap(32'h6000_0000, 32'h6666_6666, 4'hF);
    @(negedge clk);
    check("mid_rst_req", mk(0, 0, 1, 0, 0, 1, 0));
    #1 rst = 1'b1;
    #1 check("mid_rst_abandon", '0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cap(0, 0, 0);
    @(negedge clk);
    check("post_rst_idle", mk(0, 0, 0, 0, 0, 0, 0));
    step();
`ifdef STB_DRAIN_TIMEOUT_EN
    set_in(1, 32'h7000_0000, 32'h7777_7777, 4'hF, 0, 0, 0);
    step();
    cap(32'h7000_0000, 32'h7777_7777, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) check("to_wait8", mk(0, 0, 1, 0, 0, 1, 0));
      step();
    end
    @(negedge clk);
    check("to_err_set", mk(0, 0, 1, 0, 0, 1, 1));
    step();
    bus.dcache2stb_ack = 1'b1;
    @(negedge clk);
    check("to_late_ack", mk(0, 1, 1, 0, 0, 1, 1));
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("to_gap_sticky", mk(0, 0, 0, 0, 0, 1, 1));
    step();
    @(negedge clk);
    check("to_idle_sticky", mk(0, 0, 0, 0, 0, 0, 1));
    #1 rst = 1'b1;
    cap(0, 0, 0);
    #1 check("to_rst_clear", '0);
    step();
    rst = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
